// File: rtl/add_pkg.sv
// Shared definitions for the sliced adder/subtractor.
package add_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Width of a counter that must hold 0..n-1, never narrower than one bit
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational ripple-carry adder for one CHUNK-bit slice.
module chunk_adder #(
    parameter int unsigned CHUNK = 4
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             c_i,
    output logic [CHUNK-1:0] sum_o,
    output logic             c_o
);

    logic [CHUNK:0] carry_c;

    // Ripple the carry through CHUNK full adders
    always_comb begin
        carry_c    = '0;
        sum_o      = '0;
        carry_c[0] = c_i;
        for (int unsigned i = 0; i < CHUNK; i++) begin
            sum_o[i]       = a_i[i] ^ b_i[i] ^ carry_c[i];
            carry_c[i + 1] = (a_i[i] & b_i[i]) | (carry_c[i] & (a_i[i] ^ b_i[i]));
        end
        c_o = carry_c[CHUNK];
    end

endmodule

// File: rtl/seq_add_sub_n.sv
// Multi-cycle WIDTH-bit adder/subtractor: one CHUNK-bit slice per clock,
// slices linked through a registered carry, start/busy/done handshake.
module seq_add_sub_n
    import add_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow
);

    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned IDXW   = idx_width(NCHUNK);
    localparam int unsigned MSB    = WIDTH - 1;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] part_q, part_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             c_out_q, c_out_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [IDXW-1:0]  idx_q, idx_d;

    logic [CHUNK-1:0] a_sl_c, b_sl_c, s_sl_c;
    logic             co_sl_c;
    logic             accept_c;
    logic             last_c;

    // A request is taken in any state except RUN (DONE allows back-to-back)
    assign accept_c = start && (state_q != ST_RUN);
    assign last_c   = (state_q == ST_RUN) && (idx_q == IDXW'(NCHUNK - 1));

    // Pick the slice of the latched operands addressed by the index
    always_comb begin
        a_sl_c = '0;
        b_sl_c = '0;
        for (int unsigned k = 0; k < NCHUNK; k++) begin
            if (idx_q == IDXW'(k)) begin
                a_sl_c = a_q[k*CHUNK +: CHUNK];
                b_sl_c = b_q[k*CHUNK +: CHUNK];
            end
        end
    end

    chunk_adder #(
        .CHUNK (CHUNK)
    ) u_chunk_adder (
        .a_i   (a_sl_c),
        .b_i   (b_sl_c),
        .c_i   (carry_q),
        .sum_o (s_sl_c),
        .c_o   (co_sl_c)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_RUN;
            ST_RUN:  if (last_c) state_d = ST_DONE;
            ST_DONE: state_d = start ? ST_RUN : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath and output next values
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        part_d  = part_q;
        sum_d   = sum_q;
        c_out_d = c_out_q;
        ovf_d   = ovf_q;
        busy_d  = (state_d == ST_RUN);
        done_d  = last_c;
        if (accept_c) begin
            // Subtract is a + ~b + 1, so the carry register seeds the +1
            a_d     = a;
            b_d     = sub ? ~b : b;
            carry_d = sub | c_in;
            idx_d   = '0;
        end else if (state_q == ST_RUN) begin
            for (int unsigned k = 0; k < NCHUNK; k++) begin
                if (idx_q == IDXW'(k)) begin
                    part_d[k*CHUNK +: CHUNK] = s_sl_c;
                end
            end
            carry_d = co_sl_c;
            if (last_c) begin
                // Carry into the MSB recovered from the MSB sum bit
                sum_d   = part_d;
                c_out_d = co_sl_c;
                ovf_d   = a_q[MSB] ^ b_q[MSB] ^ s_sl_c[CHUNK-1] ^ co_sl_c;
            end else begin
                idx_d = idx_q + IDXW'(1);
            end
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            part_q  <= '0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            part_q  <= part_d;
            sum_q   <= sum_d;
            c_out_q <= c_out_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign sum      = sum_q;
    assign c_out    = c_out_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_seq_add_sub_n.sv
// Bench for seq_add_sub_n: directed table, handshake sequences and a
// randomized sweep over four WIDTH/CHUNK configurations.
module tb_seq_add_sub_n;

    localparam int NI = 4;
    localparam int W_T [NI] = '{16, 16, 16, 32};
    localparam int N_T [NI] = '{4, 16, 1, 4};

    logic        clk = 1'b0;
    logic        reset;
    logic        start_v [NI];
    logic        sub_v   [NI];
    logic        cin_v   [NI];
    logic [31:0] a_v     [NI];
    logic [31:0] b_v     [NI];
    logic [NI-1:0] busy_v, done_v, co_v, ov_v;
    logic [15:0] s0, s1, s2;
    logic [31:0] s3;
    logic [31:0] sum_v [NI];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign sum_v[0] = 32'(s0);
    assign sum_v[1] = 32'(s1);
    assign sum_v[2] = 32'(s2);
    assign sum_v[3] = s3;

    seq_add_sub_n #(.WIDTH(16), .CHUNK(4)) u_dut0 (
        .clk(clk), .reset(reset), .start(start_v[0]), .sub(sub_v[0]),
        .a(a_v[0][15:0]), .b(b_v[0][15:0]), .c_in(cin_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .sum(s0), .c_out(co_v[0]), .overflow(ov_v[0]));
    seq_add_sub_n #(.WIDTH(16), .CHUNK(1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start_v[1]), .sub(sub_v[1]),
        .a(a_v[1][15:0]), .b(b_v[1][15:0]), .c_in(cin_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .sum(s1), .c_out(co_v[1]), .overflow(ov_v[1]));
    seq_add_sub_n #(.WIDTH(16), .CHUNK(16)) u_dut2 (
        .clk(clk), .reset(reset), .start(start_v[2]), .sub(sub_v[2]),
        .a(a_v[2][15:0]), .b(b_v[2][15:0]), .c_in(cin_v[2]),
        .busy(busy_v[2]), .done(done_v[2]), .sum(s2), .c_out(co_v[2]), .overflow(ov_v[2]));
    seq_add_sub_n #(.WIDTH(32), .CHUNK(8)) u_dut3 (
        .clk(clk), .reset(reset), .start(start_v[3]), .sub(sub_v[3]),
        .a(a_v[3]), .b(b_v[3]), .c_in(cin_v[3]),
        .busy(busy_v[3]), .done(done_v[3]), .sum(s3), .c_out(co_v[3]), .overflow(ov_v[3]));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: unsigned sum for result/carry, signed range test for overflow
    task automatic model(input int w, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input logic ci,
                         output logic [31:0] rs, output logic rco, output logic rov);
        longint unsigned mask, aa, bb, full;
        longint sa, sb, r, lo, hi;
        mask = (64'd1 << w) - 64'd1;
        aa   = 64'(a) & mask;
        bb   = s ? (~64'(b)) & mask : 64'(b) & mask;
        full = aa + bb + (s ? 64'd1 : 64'(ci));
        rs   = 32'(full & mask);
        rco  = full[w];
        sa   = a[w-1] ? longint'(64'(a) & mask) - (longint'(1) <<< w) : longint'(64'(a) & mask);
        sb   = b[w-1] ? longint'(64'(b) & mask) - (longint'(1) <<< w) : longint'(64'(b) & mask);
        r    = s ? sa - sb : sa + sb + longint'(ci);
        hi   = (longint'(1) <<< (w - 1)) - 1;
        lo   = -(longint'(1) <<< (w - 1));
        rov  = (r > hi) || (r < lo);
    endtask

    // Issue one operation on instance k and wait (bounded) for done
    task automatic run_op(input int k, input logic [31:0] aa, input logic [31:0] bb,
                          input logic s, input logic ci,
                          output logic [31:0] rs, output logic rco, output logic rov,
                          output int lat);
        @(negedge clk);
        start_v[k] = 1'b1;
        a_v[k] = aa;
        b_v[k] = bb;
        sub_v[k] = s;
        cin_v[k] = ci;
        @(posedge clk);
        #1;
        start_v[k] = 1'b0;
        a_v[k] = $urandom;
        b_v[k] = $urandom;
        lat = 0;
        while (done_v[k] !== 1'b1 && lat < 64) begin
            @(posedge clk);
            #1;
            lat++;
        end
        rs  = sum_v[k];
        rco = co_v[k];
        rov = ov_v[k];
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        s;
        logic        ci;
        logic [15:0] e_sum;
        logic        e_co;
        logic        e_ov;
    } vec_t;

    vec_t vecs [8];

    initial begin
        logic [31:0] rs, es, prev, r1, r2, ra, rb;
        logic        rco, rov, eco, eov, s, ci;
        int          lat, gap;
        bit          seen;

        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0};
        vecs[4] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[5] = '{16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1};
        vecs[6] = '{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[7] = '{16'h00FF, 16'h0F00, 1'b0, 1'b1, 16'h1000, 1'b0, 1'b0};

        for (int k = 0; k < NI; k++) begin
            start_v[k] = 1'b0; sub_v[k] = 1'b0; cin_v[k] = 1'b0;
            a_v[k] = '0; b_v[k] = '0;
        end
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reset state on every configuration
        for (int k = 0; k < NI; k++) begin
            check($sformatf("rst_busy%0d", k), 64'(busy_v[k]), 64'd0);
            check($sformatf("rst_done%0d", k), 64'(done_v[k]), 64'd0);
            check($sformatf("rst_sum%0d", k), 64'(sum_v[k]), 64'd0);
            check($sformatf("rst_cout%0d", k), 64'(co_v[k]), 64'd0);
            check($sformatf("rst_ovf%0d", k), 64'(ov_v[k]), 64'd0);
        end

        // Directed vectors on the 16/4 instance
        for (int i = 0; i < 8; i++) begin
            run_op(0, 32'(vecs[i].a), 32'(vecs[i].b), vecs[i].s, vecs[i].ci, rs, rco, rov, lat);
            check($sformatf("vec%0d_lat", i), 64'(lat), 64'd4);
            check($sformatf("vec%0d_sum", i), 64'(rs), 64'(vecs[i].e_sum));
            check($sformatf("vec%0d_cout", i), 64'(rco), 64'(vecs[i].e_co));
            check($sformatf("vec%0d_ovf", i), 64'(rov), 64'(vecs[i].e_ov));
        end

        // start mid-RUN is ignored; outputs hold through RUN; busy for 4 cycles
        prev = sum_v[0];
        @(negedge clk);
        start_v[0] = 1'b1; a_v[0] = 32'h1111; b_v[0] = 32'h2222; sub_v[0] = 1'b0; cin_v[0] = 1'b0;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        for (int c = 0; c < 4; c++) begin
            check($sformatf("hold_busy%0d", c), 64'(busy_v[0]), 64'd1);
            check($sformatf("hold_done%0d", c), 64'(done_v[0]), 64'd0);
            check($sformatf("hold_sum%0d", c), 64'(sum_v[0]), 64'(prev));
            start_v[0] = (c == 1);
            a_v[0] = 32'hFFFF; b_v[0] = 32'hFFFF; sub_v[0] = 1'b1;
            @(posedge clk); #1;
        end
        start_v[0] = 1'b0;
        check("ign_done", 64'(done_v[0]), 64'd1);
        check("ign_busy", 64'(busy_v[0]), 64'd0);
        check("ign_sum", 64'(sum_v[0]), 64'h3333);
        @(posedge clk); #1;
        check("ign_no_restart", 64'(busy_v[0]), 64'd0);

        // start held into the DONE cycle: back-to-back with 5-cycle spacing
        @(negedge clk);
        start_v[0] = 1'b1; a_v[0] = 32'h0001; b_v[0] = 32'h0002; sub_v[0] = 1'b0; cin_v[0] = 1'b0;
        @(posedge clk); #1;
        a_v[0] = 32'h0100; b_v[0] = 32'h0300; sub_v[0] = 1'b1;
        lat = 0;
        while (done_v[0] !== 1'b1 && lat < 64) begin @(posedge clk); #1; lat++; end
        check("b2b_lat1", 64'(lat), 64'd4);
        check("b2b_sum1", 64'(sum_v[0]), 64'h0003);
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        gap = 1;
        check("b2b_busy", 64'(busy_v[0]), 64'd1);
        while (done_v[0] !== 1'b1 && gap < 64) begin @(posedge clk); #1; gap++; end
        check("b2b_gap", 64'(gap), 64'd5);
        check("b2b_sum2", 64'(sum_v[0]), 64'hFE00);
        check("b2b_cout2", 64'(co_v[0]), 64'd0);

        // reset at E2 of a run discards it
        @(negedge clk);
        start_v[0] = 1'b1; a_v[0] = 32'h7FFF; b_v[0] = 32'h7FFF; sub_v[0] = 1'b0;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("rstrun_busy", 64'(busy_v[0]), 64'd0);
        check("rstrun_done", 64'(done_v[0]), 64'd0);
        check("rstrun_sum", 64'(sum_v[0]), 64'd0);
        check("rstrun_cout", 64'(co_v[0]), 64'd0);
        check("rstrun_ovf", 64'(ov_v[0]), 64'd0);
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (done_v[0] === 1'b1 || busy_v[0] === 1'b1) seen = 1'b1;
        end
        check("rstrun_quiet", 64'(seen), 64'd0);
        run_op(0, 32'h0F0F, 32'h00F1, 1'b0, 1'b0, rs, rco, rov, lat);
        check("rstrun_after_lat", 64'(lat), 64'd4);
        check("rstrun_after_sum", 64'(rs), 64'h1000);

        // Randomized sweep on every configuration against the model
        for (int k = 0; k < NI; k++) begin
            for (int n = 0; n < 1000; n++) begin
                ra = $urandom;
                rb = $urandom;
                case ($urandom_range(0, 5))
                    0: ra = '0;
                    1: ra = 32'hFFFF_FFFF;
                    2: ra = 32'(1) << (W_T[k] - 1);
                    3: rb = (32'(1) << (W_T[k] - 1)) - 32'd1;
                    default: ;
                endcase
                s  = 1'($urandom_range(0, 1));
                ci = 1'($urandom_range(0, 1));
                model(W_T[k], ra, rb, s, ci, es, eco, eov);
                run_op(k, ra, rb, s, ci, rs, rco, rov, lat);
                check($sformatf("rnd%0d_%0d_lat", k, n), 64'(lat), 64'(N_T[k]));
                check($sformatf("rnd%0d_%0d_sum", k, n), 64'(rs), 64'(es));
                check($sformatf("rnd%0d_%0d_cout", k, n), 64'(rco), 64'(eco));
                check($sformatf("rnd%0d_%0d_ovf", k, n), 64'(rov), 64'(eov));
            end
        end

        r1 = '0; r2 = '0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
